xbar_switch_alloc: RTL and testbench
====================================

Name: xbar_switch_alloc

Overview:
Switch allocator that drives the one-hot select inputs of the 5x5 registered router crossbar (8-bit flits). Each of the 5 input buffers presents a one-hot output-port request for its head flit. Each output port runs an independent round-robin arbiter with optional wormhole (packet) locking. The block produces per-output selects, per-input pop grants and output-valid flags aligned to the crossbar's registered outputs.

Parameters:
NPORT, 5, number of ports; only 5 is supported, matching the crossbar.
LOCK_PKT, 1, 1 = hold an output for a packet until its tail flit; 0 = arbitrate every flit, tail ignored.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req0..req4  input  5 each  one-hot requested output for head flit of input i; 00000 = no request
tail  input  5  bit i = head flit of input i is a packet tail
out_rdy  input  5  bit k = output k can accept a flit this cycle
sel0..sel4  output  5 each  one-hot crossbar select for output k, bit j = input j; 00000 = idle
gnt  output  5  bit i = input i's head flit transfers this cycle; buffer pops at this edge
out_vld  output  5  registered; bit k = crossbar output k holds a valid flit
err  output  1  registered, sticky; a non-one-hot nonzero req was seen

Behaviour:
- State: per-output rr pointer ptr_k (0..4), lock_k bit, owner_k (0..4), out_vld, err.
- sel_k and gnt are combinational (Mealy) from state and current req/tail/out_rdy. The crossbar captures i_j at the same edge where the buffer pops, so transfer latency is 0 cycles to capture and 1 cycle to the crossbar output.
- gnt[j] = OR over k of sel_k[j]. At most one bit is set per sel_k. An input requests only one output, so gnt is never double-counted.
- A req_i that is not one-hot (and not zero) is treated as no request; err <= 1 at the next edge.
- Locked output k (lock_k=1): sel_k[owner_k] = req_owner[k] & out_rdy[k]. All other requesters for k are blocked. If the owner drops its request, the lock persists and the output stays idle. On a granted flit with tail[owner]=1, lock_k <= 0.
- Unlocked output k: the winner is the first input j, scanning ptr_k, ptr_k+1, ... mod 5 (4 wraps to 0), with req_j[k]=1.
  - Grant only if out_rdy[k]=1.
  - On grant: ptr_k <= (winner+1) mod 5.
  - If LOCK_PKT=1 and tail[winner]=0: lock_k <= 1 and owner_k <= winner.
  - A single-flit packet (tail set on the first flit) never locks.
- out_rdy[k]=0: sel_k=0 and no gnt for k. ptr_k and the lock are unchanged. Arbitration is re-evaluated next cycle, so the winner may change if the output is unlocked.
- ptr_k is frozen during locked transfers and advances only on unlocked grants.
- out_vld[k] <= |sel_k each edge, aligned with the crossbar's registered o_k.
- Reset (rst=0, asynchronous):
  - all ptr_k = 0, lock_k = 0, out_vld = 0, err = 0.
  - sel0..sel4 and gnt are forced to 0 while rst=0, regardless of req.
  - Reset mid-packet drops all locks; the first arbitration after release starts from pointer 0.
- Simultaneous events: a tail grant and a new request on the same output in one cycle → the lock clears at the edge; the new request is arbitrated next cycle with the updated pointer.

Test Plan:
1. Release reset, all req=0, out_rdy=11111 → sel0..sel4=00000, gnt=00000, out_vld=00000, err=0 for 10 cycles.
2. Inputs 0,1,2 continuously request output 3 with single-flit packets (tail=11111), out_rdy=11111 → sel3 sequence 00001, 00010, 00100, 00001…; gnt follows the same pattern; out_vld[3]=1 from the cycle after the first grant.
3. Input 4 sends a 3-flit packet to output 0 (tail only on flit 3); input 1 requests output 0 from the second cycle → sel0=10000 for 3 cycles, then 00010; ptr_0 ends at 2.
4. Input 2 requests output 2 with out_rdy[2]=0 for 2 cycles → sel2=0, gnt=0. When out_rdy[2] rises → sel2=00100 and gnt=00100 in the same cycle; out_vld[2]=1 on the next cycle.
5. Permutation: inputs 0..4 request outputs 1, 2, 0, 4, 3 simultaneously (single-flit) → sel0=00100, sel1=00001, sel2=00010, sel3=10000, sel4=01000, gnt=11111.
6. req0=00101 → ignored (sel all 0) and err=1, held sticky. Then start a locked packet and assert rst mid-packet → outputs 0 immediately, lock cleared, err=0. After release, a competing input wins based on ptr=0.

Source files
------------

// File: rtl/xbar_switch_alloc.sv
// Switch allocator for the 5x5 registered router crossbar: one round-robin arbiter per
// output with optional wormhole locking; produces crossbar selects, buffer pops and output-valid flags.
module xbar_switch_alloc #(
    parameter int NPORT    = 5,
    parameter bit LOCK_PKT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req0,
    input  logic [NPORT-1:0] req1,
    input  logic [NPORT-1:0] req2,
    input  logic [NPORT-1:0] req3,
    input  logic [NPORT-1:0] req4,
    input  logic [NPORT-1:0] tail,
    input  logic [NPORT-1:0] out_rdy,
    output logic [NPORT-1:0] sel0,
    output logic [NPORT-1:0] sel1,
    output logic [NPORT-1:0] sel2,
    output logic [NPORT-1:0] sel3,
    output logic [NPORT-1:0] sel4,
    output logic [NPORT-1:0] gnt,
    output logic [NPORT-1:0] out_vld,
    output logic             err
);

    logic [NPORT-1:0] req_a [NPORT];
    logic [NPORT-1:0] req_v [NPORT];
    logic [NPORT-1:0] sel   [NPORT];
    logic [2:0]       win   [NPORT];
    logic [NPORT-1:0] win_vld;
    logic [NPORT-1:0] grant;
    logic [3:0]       idx;
    logic             bad_req;

    logic [2:0]       ptr_q   [NPORT];
    logic [2:0]       ptr_d   [NPORT];
    logic [2:0]       owner_q [NPORT];
    logic [2:0]       owner_d [NPORT];
    logic [NPORT-1:0] lock_q, lock_d;
    logic [NPORT-1:0] out_vld_q, out_vld_d;
    logic             err_q, err_d;

    assign req_a[0] = req0;
    assign req_a[1] = req1;
    assign req_a[2] = req2;
    assign req_a[3] = req3;
    assign req_a[4] = req4;

    // Transpose valid requests so req_v[k][j] means input j wants output k;
    // malformed (multi-hot) requests are dropped here and only flagged.
    always_comb begin
        bad_req = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            req_v[k] = '0;
        end
        for (int j = 0; j < NPORT; j++) begin
            if ((req_a[j] != '0) && !$onehot(req_a[j])) begin
                bad_req = 1'b1;
            end
            for (int k = 0; k < NPORT; k++) begin
                req_v[k][j] = $onehot(req_a[j]) & req_a[j][k];
            end
        end
    end

    // Per-output winner: the lock owner if locked, otherwise first requester from ptr.
    always_comb begin
        idx     = '0;
        win_vld = '0;
        grant   = '0;
        for (int k = 0; k < NPORT; k++) begin
            win[k] = '0;
            sel[k] = '0;
            if (lock_q[k]) begin
                win[k]     = owner_q[k];
                win_vld[k] = req_v[k][owner_q[k]];
            end else begin
                for (int o = 0; o < NPORT; o++) begin
                    idx = {1'b0, ptr_q[k]} + 4'(o);
                    if (idx >= 4'(NPORT)) begin
                        idx = idx - 4'(NPORT);
                    end
                    if (!win_vld[k] && req_v[k][idx[2:0]]) begin
                        win_vld[k] = 1'b1;
                        win[k]     = idx[2:0];
                    end
                end
            end
            grant[k] = win_vld[k] & out_rdy[k] & rst;
            if (grant[k]) begin
                sel[k][win[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int k = 0; k < NPORT; k++) begin
            gnt = gnt | sel[k];
        end
    end

    always_comb begin
        lock_d    = lock_q;
        out_vld_d = grant;
        err_d     = err_q | bad_req;
        for (int k = 0; k < NPORT; k++) begin
            ptr_d[k]   = ptr_q[k];
            owner_d[k] = owner_q[k];
            if (grant[k]) begin
                if (lock_q[k]) begin
                    if (tail[win[k]]) begin
                        lock_d[k] = 1'b0;
                    end
                end else begin
                    ptr_d[k] = (win[k] == 3'(NPORT - 1)) ? 3'd0 : win[k] + 3'd1;
                    if (LOCK_PKT && !tail[win[k]]) begin
                        lock_d[k]  = 1'b1;
                        owner_d[k] = win[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NPORT; k++) begin
                ptr_q[k]   <= '0;
                owner_q[k] <= '0;
            end
            lock_q    <= '0;
            out_vld_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                ptr_q[k]   <= ptr_d[k];
                owner_q[k] <= owner_d[k];
            end
            lock_q    <= lock_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
        end
    end

    assign sel0    = sel[0];
    assign sel1    = sel[1];
    assign sel2    = sel[2];
    assign sel3    = sel[3];
    assign sel4    = sel[4];
    assign out_vld = out_vld_q;
    assign err     = err_q;

endmodule

// File: tb/tb_xbar_switch_alloc.sv
// Bench for xbar_switch_alloc: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a behavioural allocator model.
module tb_xbar_switch_alloc;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req [5];
    logic [4:0] tail, out_rdy;
    logic [4:0] sel [5];
    logic [4:0] gnt, out_vld;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int         m_ptr   [5];
    int         m_owner [5];
    bit         m_lock  [5];
    logic [4:0] m_vld;
    bit         m_err;
    logic [4:0] e_sel [5];
    logic [4:0] e_gnt;
    int         e_win [5];
    bit         e_g   [5];

    always #5 clk = ~clk;

    xbar_switch_alloc dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]), .req4(req[4]),
        .tail(tail), .out_rdy(out_rdy),
        .sel0(sel[0]), .sel1(sel[1]), .sel2(sel[2]), .sel3(sel[3]), .sel4(sel[4]),
        .gnt(gnt), .out_vld(out_vld), .err(err)
    );

    task automatic checkVal(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reqv(input int i, input int k);
        return ($countones(req[i]) == 1) && req[i][k];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 5; k++) begin
            m_ptr[k]   = 0;
            m_owner[k] = 0;
            m_lock[k]  = 1'b0;
        end
        m_vld = '0;
        m_err = 1'b0;
    endtask

    task automatic modelEval();
        bit found;
        int w;
        if (!rst) modelReset();
        e_gnt = '0;
        for (int k = 0; k < 5; k++) begin
            e_sel[k] = '0;
            found    = 1'b0;
            w        = 0;
            if (m_lock[k]) begin
                w     = m_owner[k];
                found = reqv(w, k);
            end else begin
                for (int o = 0; o < 5; o++) begin
                    int j;
                    j = (m_ptr[k] + o) % 5;
                    if (!found && reqv(j, k)) begin
                        found = 1'b1;
                        w     = j;
                    end
                end
            end
            e_g[k]   = found && out_rdy[k] && (rst == 1'b1);
            e_win[k] = w;
            if (e_g[k]) e_sel[k][w] = 1'b1;
            e_gnt = e_gnt | e_sel[k];
        end
    endtask

    task automatic modelUpdate();
        if (!rst) begin
            modelReset();
            return;
        end
        for (int k = 0; k < 5; k++) begin
            m_vld[k] = e_g[k];
            if (e_g[k]) begin
                if (m_lock[k]) begin
                    if (tail[e_win[k]]) m_lock[k] = 1'b0;
                end else begin
                    m_ptr[k] = (e_win[k] + 1) % 5;
                    if (!tail[e_win[k]]) begin
                        m_lock[k]  = 1'b1;
                        m_owner[k] = e_win[k];
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            if ($countones(req[i]) > 1) m_err = 1'b1;
        end
    endtask

    task automatic checkOutput();
        modelEval();
        for (int k = 0; k < 5; k++) begin
            checkVal($sformatf("sel%0d", k), sel[k], e_sel[k]);
        end
        checkVal("gnt", gnt, e_gnt);
        checkVal("out_vld", out_vld, m_vld);
        checkVal("err", {4'b0, err}, {4'b0, m_err});
    endtask

    task automatic evalCycle();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] r3, input logic [4:0] r4,
                                 input logic [4:0] tl, input logic [4:0] rdy);
        req[0] = r0; req[1] = r1; req[2] = r2; req[3] = r3; req[4] = r4;
        tail = tl;
        out_rdy = rdy;
    endtask

    initial begin
        logic [4:0] t2_exp [4];
        t2_exp[0] = 5'b00001; t2_exp[1] = 5'b00010; t2_exp[2] = 5'b00100; t2_exp[3] = 5'b00001;

        rst = 1'b0;
        applyStimulus('0, '0, '0, '0, '0, '0, 5'b11111);
        modelReset();
        repeat (3) begin evalCycle(); advance(); end
        rst = 1'b1;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            evalCycle();
            advance();
        end
        evalCycle();
        checkVal("t1_gnt", gnt, 5'b00000);
        checkVal("t1_vld", out_vld, 5'b00000);
        advance();

        // Round-robin on output 3 with single-flit packets
        applyStimulus(5'b01000, 5'b01000, 5'b01000, '0, '0, 5'b11111, 5'b11111);
        for (int c = 0; c < 4; c++) begin
            evalCycle();
            checkVal($sformatf("t2_sel3_c%0d", c), sel[3], t2_exp[c]);
            checkVal($sformatf("t2_gnt_c%0d", c), gnt, t2_exp[c]);
            if (c > 0) checkVal($sformatf("t2_vld_c%0d", c), out_vld, 5'b01000);
            advance();
        end

        // Three-flit packet from input 4 locks output 0 against input 1
        applyStimulus('0, '0, '0, '0, 5'b00001, 5'b00000, 5'b11111);
        evalCycle(); checkVal("t3_sel0_f1", sel[0], 5'b10000); advance();
        applyStimulus('0, 5'b00001, '0, '0, 5'b00001, 5'b00000, 5'b11111);
        evalCycle(); checkVal("t3_sel0_f2", sel[0], 5'b10000); advance();
        applyStimulus('0, 5'b00001, '0, '0, 5'b00001, 5'b10000, 5'b11111);
        evalCycle(); checkVal("t3_sel0_f3", sel[0], 5'b10000); advance();
        applyStimulus('0, 5'b00001, '0, '0, '0, 5'b00010, 5'b11111);
        evalCycle(); checkVal("t3_sel0_in1", sel[0], 5'b00010); advance();
        checkVal("t3_model_ptr0", 5'(m_ptr[0]), 5'd2);

        // Backpressure on output 2
        applyStimulus('0, '0, 5'b00100, '0, '0, 5'b11111, 5'b11011);
        for (int c = 0; c < 2; c++) begin
            evalCycle();
            checkVal($sformatf("t4_sel2_c%0d", c), sel[2], 5'b00000);
            checkVal($sformatf("t4_gnt_c%0d", c), gnt, 5'b00000);
            advance();
        end
        out_rdy = 5'b11111;
        evalCycle(); checkVal("t4_sel2_rdy", sel[2], 5'b00100); checkVal("t4_gnt_rdy", gnt, 5'b00100); advance();
        applyStimulus('0, '0, '0, '0, '0, 5'b11111, 5'b11111);
        evalCycle(); checkVal("t4_vld", out_vld, 5'b00100); advance();

        // Full permutation
        applyStimulus(5'b00010, 5'b00100, 5'b00001, 5'b10000, 5'b01000, 5'b11111, 5'b11111);
        evalCycle();
        checkVal("t5_sel0", sel[0], 5'b00100);
        checkVal("t5_sel1", sel[1], 5'b00001);
        checkVal("t5_sel2", sel[2], 5'b00010);
        checkVal("t5_sel3", sel[3], 5'b10000);
        checkVal("t5_sel4", sel[4], 5'b01000);
        checkVal("t5_gnt", gnt, 5'b11111);
        advance();

        // Malformed request, then reset in the middle of a locked packet
        applyStimulus(5'b00101, '0, '0, '0, '0, 5'b11111, 5'b11111);
        evalCycle(); checkVal("t6_gnt_bad", gnt, 5'b00000); advance();
        applyStimulus('0, '0, '0, '0, '0, 5'b11111, 5'b11111);
        evalCycle(); checkVal("t6_err_set", {4'b0, err}, 5'b00001); advance();
        applyStimulus('0, '0, 5'b00010, '0, '0, 5'b00000, 5'b11111);
        evalCycle(); checkVal("t6_sel1_lock", sel[1], 5'b00100); advance();
        rst = 1'b0;
        evalCycle();
        checkVal("t6_sel1_rst", sel[1], 5'b00000);
        checkVal("t6_gnt_rst", gnt, 5'b00000);
        checkVal("t6_err_rst", {4'b0, err}, 5'b00000);
        advance();
        rst = 1'b1;
        applyStimulus(5'b00010, '0, '0, '0, 5'b00010, 5'b11111, 5'b11111);
        evalCycle(); checkVal("t6_sel1_after", sel[1], 5'b00001); advance();

        // Random traffic, concentrated on a few outputs to force contention
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 5; i++) begin
                int r;
                r = $urandom_range(0, 19);
                if (r < 7)       req[i] = '0;
                else if (r < 13) req[i] = 5'(1 << $urandom_range(0, 1));
                else if (r < 19) req[i] = 5'(1 << $urandom_range(0, 4));
                else             req[i] = 5'($urandom_range(0, 31));
            end
            tail    = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            out_rdy = 5'($urandom_range(0, 31) | $urandom_range(0, 31));
            rst     = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            evalCycle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
